bmm_block_feeder: RTL and testbench

Upstream stage of the block matrix multiplier. It captures a full SIZE×SIZE operand pair A and B in one handshake and then issues every (row-block, column-block) tile pair to `bmm_partial`, one tile per accepted transfer. Each tile pair is BLOCK_SIZE full rows of A and BLOCK_SIZE full columns of B, packed in exactly the layout `bmm_partial` unpacks. Tiles are issued in row-major tile order with tile-index side-band for the downstream collector.

---
 rtl/bmm_pkg.sv | 25 ++
 rtl/bmm_tile_select.sv | 36 +++
 rtl/bmm_block_feeder.sv | 142 ++++++++++++++
 tb/tb_bmm_block_feeder.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmm_pkg.sv
// Shared constants, helpers and state type for the block matrix multiplier.
// NT/IW describe the default 4x4 matrix with 2x2 tiles.
package bmm_pkg;

    localparam int SIZE_DEF       = 4;
    localparam int BLOCK_SIZE_DEF = 2;

    function automatic int calc_iw(input int nt);
        return (nt > 1) ? $clog2(nt) : 1;
    endfunction

    localparam int NT = SIZE_DEF / BLOCK_SIZE_DEF;
    localparam int IW = calc_iw(NT);

    // Element index in a row-major packed matrix; scale by DATA_WIDTH for bits.
    function automatic int elem_off(input int row, input int col, input int width);
        return row * width + col;
    endfunction

    typedef enum logic {
        IDLE,
        ISSUE
    } feeder_state_e;

endpackage

// File: rtl/bmm_tile_select.sv
// Combinational slicer: picks BLOCK_SIZE rows of A and BLOCK_SIZE columns of B
// for the requested tile and repacks them into the bmm_partial layout.
module bmm_tile_select
    import bmm_pkg::*;
#(
    parameter int BLOCK_SIZE = 2,
    parameter int DATA_WIDTH = 4,
    parameter int SIZE       = 4,
    parameter int IDX_W      = 1
) (
    input  logic [SIZE*SIZE*DATA_WIDTH-1:0]       a_mat,
    input  logic [SIZE*SIZE*DATA_WIDTH-1:0]       b_mat,
    input  logic [IDX_W-1:0]                      tile_row,
    input  logic [IDX_W-1:0]                      tile_col,
    output logic [BLOCK_SIZE*SIZE*DATA_WIDTH-1:0] a_rows,
    output logic [SIZE*BLOCK_SIZE*DATA_WIDTH-1:0] b_cols
);

    always_comb begin
        a_rows = '0;
        b_cols = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            for (int k = 0; k < SIZE; k++) begin
                a_rows[elem_off(i, k, SIZE)*DATA_WIDTH +: DATA_WIDTH] =
                    a_mat[elem_off(int'(tile_row)*BLOCK_SIZE + i, k, SIZE)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        for (int k = 0; k < SIZE; k++) begin
            for (int j = 0; j < BLOCK_SIZE; j++) begin
                b_cols[elem_off(k, j, BLOCK_SIZE)*DATA_WIDTH +: DATA_WIDTH] =
                    b_mat[elem_off(k, int'(tile_col)*BLOCK_SIZE + j, SIZE)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/bmm_block_feeder.sv
// Captures a full A/B operand pair and issues every tile pair to bmm_partial
// in row-major tile order, one tile per accepted transfer.
module bmm_block_feeder
    import bmm_pkg::*;
#(
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
    parameter int DATA_WIDTH = 4,
    parameter int SIZE       = SIZE_DEF,
    localparam int N_TILES   = SIZE / BLOCK_SIZE,
    localparam int IDX_W     = calc_iw(N_TILES),
    localparam int MAT_W     = SIZE * SIZE * DATA_WIDTH,
    localparam int TILE_W    = BLOCK_SIZE * SIZE * DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [MAT_W-1:0]  A_in,
    input  logic [MAT_W-1:0]  B_in,
    output logic [TILE_W-1:0] A_rows,
    output logic [TILE_W-1:0] B_cols,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [IDX_W-1:0]  tile_row,
    output logic [IDX_W-1:0]  tile_col,
    output logic              last_tile,
    output logic              done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TILES - 1);

    feeder_state_e     state_q, state_d;
    logic [MAT_W-1:0]  a_mat_q, a_mat_d;
    logic [MAT_W-1:0]  b_mat_q, b_mat_d;
    logic [IDX_W-1:0]  tile_row_q, tile_row_d;
    logic [IDX_W-1:0]  tile_col_q, tile_col_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic [TILE_W-1:0] a_rows_q, a_rows_d;
    logic [TILE_W-1:0] b_cols_q, b_cols_d;
    logic [TILE_W-1:0] sel_a;
    logic [TILE_W-1:0] sel_b;

    always_comb begin
        state_d    = state_q;
        a_mat_d    = a_mat_q;
        b_mat_d    = b_mat_q;
        tile_row_d = tile_row_q;
        tile_col_d = tile_col_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    a_mat_d    = A_in;
                    b_mat_d    = B_in;
                    tile_row_d = '0;
                    tile_col_d = '0;
                    valid_d    = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (ready_in) begin
                    if (last_q) begin
                        tile_row_d = '0;
                        tile_col_d = '0;
                        valid_d    = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else if (tile_col_q < LAST_IDX) begin
                        tile_col_d = tile_col_q + IDX_W'(1);
                    end else begin
                        tile_col_d = '0;
                        tile_row_d = tile_row_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        last_d = valid_d && (tile_row_d == LAST_IDX) && (tile_col_d == LAST_IDX);
    end

    // Slice from the next-cycle storage and indices so the outputs are registered.
    bmm_tile_select #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .SIZE       (SIZE),
        .IDX_W      (IDX_W)
    ) u_tile_select (
        .a_mat    (a_mat_d),
        .b_mat    (b_mat_d),
        .tile_row (tile_row_d),
        .tile_col (tile_col_d),
        .a_rows   (sel_a),
        .b_cols   (sel_b)
    );

    always_comb begin
        a_rows_d = valid_d ? sel_a : '0;
        b_cols_d = valid_d ? sel_b : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tile_row_q <= '0;
            tile_col_q <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            a_rows_q   <= '0;
            b_cols_q   <= '0;
        end else begin
            state_q    <= state_d;
            tile_row_q <= tile_row_d;
            tile_col_q <= tile_col_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            done_q     <= done_d;
            a_rows_q   <= a_rows_d;
            b_cols_q   <= b_cols_d;
        end
    end

    // Operand storage needs no reset; it only changes on an accepted load.
    always_ff @(posedge clk) begin
        a_mat_q <= a_mat_d;
        b_mat_q <= b_mat_d;
    end

    assign load_ready = (state_q == IDLE);
    assign A_rows     = a_rows_q;
    assign B_cols     = b_cols_q;
    assign valid_out  = valid_q;
    assign tile_row   = tile_row_q;
    assign tile_col   = tile_col_q;
    assign last_tile  = last_q;
    assign done       = done_q;

endmodule

// File: tb/tb_bmm_block_feeder.sv
// Scoreboard bench for bmm_block_feeder: a 4x4/2x2 instance plus a degenerate
// 2x2/2x2 instance with a single tile.
module tb_bmm_block_feeder;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [0:0]  r;
        logic [0:0]  c;
        logic        l;
    } tile_t;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [63:0] A_in, B_in;
    logic [31:0] A_rows, B_cols;
    logic        valid_out;
    logic        ready_in;
    logic [0:0]  tile_row, tile_col;
    logic        last_tile;
    logic        done;

    logic        dg_load_valid, dg_load_ready, dg_valid_out, dg_ready_in;
    logic [15:0] dg_A_in, dg_B_in, dg_A_rows, dg_B_cols;
    logic [0:0]  dg_tile_row, dg_tile_col;
    logic        dg_last_tile, dg_done;

    int    checks = 0;
    int    errors = 0;
    tile_t sb_q[$];
    tile_t exp_t;

    bmm_block_feeder #(.BLOCK_SIZE(2), .DATA_WIDTH(4), .SIZE(4)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .A_in(A_in), .B_in(B_in), .A_rows(A_rows), .B_cols(B_cols),
        .valid_out(valid_out), .ready_in(ready_in), .tile_row(tile_row),
        .tile_col(tile_col), .last_tile(last_tile), .done(done)
    );

    bmm_block_feeder #(.BLOCK_SIZE(2), .DATA_WIDTH(4), .SIZE(2)) dut_dg (
        .clk(clk), .rst(rst), .load_valid(dg_load_valid), .load_ready(dg_load_ready),
        .A_in(dg_A_in), .B_in(dg_B_in), .A_rows(dg_A_rows), .B_cols(dg_B_cols),
        .valid_out(dg_valid_out), .ready_in(dg_ready_in), .tile_row(dg_tile_row),
        .tile_col(dg_tile_col), .last_tile(dg_last_tile), .done(dg_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic make_pattern(output logic [63:0] a, output logic [63:0] b);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                a[(r*4+c)*4 +: 4] = 4'((r*4 + c) % 16);
                b[(r*4+c)*4 +: 4] = 4'(15 - r*4 - c);
            end
        end
    endtask

    task automatic make_random(output logic [63:0] a, output logic [63:0] b);
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
    endtask

    // Expected tile stream for one load, in row-major tile order.
    function automatic void push_tiles(input logic [63:0] a, input logic [63:0] b);
        tile_t t;
        for (int tr = 0; tr < 2; tr++) begin
            for (int tc = 0; tc < 2; tc++) begin
                for (int i = 0; i < 2; i++)
                    for (int k = 0; k < 4; k++)
                        t.a[(i*4+k)*4 +: 4] = a[((tr*2+i)*4+k)*4 +: 4];
                for (int k = 0; k < 4; k++)
                    for (int j = 0; j < 2; j++)
                        t.b[(k*2+j)*4 +: 4] = b[(k*4+tc*2+j)*4 +: 4];
                t.r = 1'(tr);
                t.c = 1'(tc);
                t.l = (tr == 1) && (tc == 1);
                sb_q.push_back(t);
            end
        end
    endfunction

    task automatic start_load(input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        ready_in   = 1'b1;
        A_in       = a;
        B_in       = b;
        load_valid = 1'b1;
        push_tiles(a, b);
        @(negedge clk);
        checks++;
        if ({valid_out, load_ready, tile_row, tile_col} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL first_tile_latency got valid=%b ready=%b row=%0d col=%0d exp 1 0 0 0",
                     valid_out, load_ready, tile_row, tile_col);
        end
    endtask

    task automatic check_done_pulse(input string name);
        checks++;
        if ({done, valid_out, load_ready} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL %s_done got done=%b valid=%b load_ready=%b exp 1 0 1",
                     name, done, valid_out, load_ready);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_done_width got done=%b exp 0", name, done);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({load_ready, valid_out, A_rows, B_cols, tile_row, tile_col, last_tile, done} !==
            {1'b1, 1'b0, 64'h0, 4'b0}) begin
            errors++;
            $display("[TB] FAIL reset_values got ready=%b valid=%b A=%h B=%h row=%0d col=%0d last=%b done=%b",
                     load_ready, valid_out, A_rows, B_cols, tile_row, tile_col, last_tile, done);
        end
        checks++;
        if ({dg_load_ready, dg_valid_out, dg_A_rows, dg_B_cols, dg_last_tile, dg_done} !==
            {1'b1, 1'b0, 32'h0, 2'b0}) begin
            errors++;
            $display("[TB] FAIL reset_values_dg got ready=%b valid=%b A=%h B=%h",
                     dg_load_ready, dg_valid_out, dg_A_rows, dg_B_cols);
        end
    endtask

    task automatic test_single_load();
        logic [63:0] a, b;
        int cyc = 0;
        make_pattern(a, b);
        start_load(a, b);
        load_valid = 1'b0;
        while (sb_q.size() != 0 && cyc < 20) begin
            if (valid_out && ready_in) begin
                exp_t = sb_q.pop_front();
                checks++;
                if ({A_rows, B_cols, tile_row, tile_col, last_tile} !== {exp_t.a, exp_t.b, exp_t.r, exp_t.c, exp_t.l}) begin
                    errors++;
                    $display("[TB] FAIL single_tile got r%0d c%0d A=%h B=%h l=%b exp r%0d c%0d A=%h B=%h l=%b",
                             tile_row, tile_col, A_rows, B_cols, last_tile, exp_t.r, exp_t.c, exp_t.a, exp_t.b, exp_t.l);
                end
                if (exp_t.r == 1'b1 && exp_t.c == 1'b0) begin
                    checks++;
                    if ({A_rows, B_cols} !== {32'hFEDCBA98, 32'h2367ABEF}) begin
                        errors++;
                        $display("[TB] FAIL tile_1_0_const got A=%h B=%h exp A=fedcba98 B=2367abef", A_rows, B_cols);
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("[TB] FAIL single_timeout got %0d tiles left exp 0", sb_q.size());
            sb_q.delete();
        end
        check_done_pulse("single");
    endtask

    task automatic test_backpressure();
        logic [63:0] a, b;
        logic [63:0] snap;
        logic [1:0]  snap_idx;
        int cyc = 0;
        int accepted = 0;
        bit stalled = 0;
        make_random(a, b);
        start_load(a, b);
        load_valid = 1'b0;
        while (sb_q.size() != 0 && cyc < 30) begin
            if (valid_out && !stalled && tile_row == 1'b0 && tile_col == 1'b1) begin
                stalled  = 1;
                ready_in = 1'b0;
                snap     = {A_rows, B_cols};
                snap_idx = {tile_row, tile_col};
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    checks++;
                    if ({A_rows, B_cols, tile_row, tile_col, last_tile, valid_out} !== {snap, snap_idx, 2'b01}) begin
                        errors++;
                        $display("[TB] FAIL stall_hold cycle %0d got A=%h B=%h r%0d c%0d v=%b exp %h r0 c1 v=1",
                                 s, A_rows, B_cols, tile_row, tile_col, valid_out, snap);
                    end
                end
                ready_in = 1'b1;
            end
            if (valid_out && ready_in) begin
                exp_t = sb_q.pop_front();
                accepted++;
                checks++;
                if ({A_rows, B_cols, tile_row, tile_col, last_tile} !== {exp_t.a, exp_t.b, exp_t.r, exp_t.c, exp_t.l}) begin
                    errors++;
                    $display("[TB] FAIL bp_tile got r%0d c%0d A=%h B=%h l=%b exp r%0d c%0d A=%h B=%h l=%b",
                             tile_row, tile_col, A_rows, B_cols, last_tile, exp_t.r, exp_t.c, exp_t.a, exp_t.b, exp_t.l);
                end
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (accepted != 4 || !stalled) begin
            errors++;
            $display("[TB] FAIL bp_count got accepted=%0d stalled=%0d exp 4 1", accepted, stalled);
            sb_q.delete();
        end
        check_done_pulse("bp");
    endtask

    task automatic test_load_while_busy();
        logic [63:0] a, b, a2, b2;
        int cyc = 0;
        make_pattern(a, b);
        make_random(a2, b2);
        a2[3:0] = ~a[3:0];
        start_load(a, b);
        A_in = a2;
        B_in = b2;
        while (sb_q.size() != 0 && cyc < 20) begin
            if (valid_out && ready_in) begin
                exp_t = sb_q.pop_front();
                checks++;
                if ({A_rows, B_cols, tile_row, tile_col, last_tile} !== {exp_t.a, exp_t.b, exp_t.r, exp_t.c, exp_t.l}) begin
                    errors++;
                    $display("[TB] FAIL busy_tile got r%0d c%0d A=%h B=%h l=%b exp r%0d c%0d A=%h B=%h l=%b",
                             tile_row, tile_col, A_rows, B_cols, last_tile, exp_t.r, exp_t.c, exp_t.a, exp_t.b, exp_t.l);
                end
                if (sb_q.size() == 0) load_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("[TB] FAIL busy_timeout got %0d tiles left exp 0", sb_q.size());
            sb_q.delete();
            load_valid = 1'b0;
        end
        check_done_pulse("busy");
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b, a2, b2;
        int cyc = 0;
        bit prev_done = 0;
        bit saw_done = 0;
        make_pattern(a, b);
        make_random(a2, b2);
        start_load(a, b);
        A_in = a2;
        B_in = b2;
        push_tiles(a2, b2);
        while (sb_q.size() != 0 && cyc < 30) begin
            if (prev_done) begin
                load_valid = 1'b0;
                checks++;
                if ({valid_out, tile_row, tile_col} !== 3'b100) begin
                    errors++;
                    $display("[TB] FAIL b2b_restart got valid=%b r%0d c%0d exp 1 r0 c0", valid_out, tile_row, tile_col);
                end
            end
            if (done) begin
                saw_done = 1;
                checks++;
                if ({load_ready, valid_out} !== 2'b10) begin
                    errors++;
                    $display("[TB] FAIL b2b_gap got load_ready=%b valid=%b exp 1 0", load_ready, valid_out);
                end
            end
            prev_done = done;
            if (valid_out && ready_in) begin
                exp_t = sb_q.pop_front();
                checks++;
                if ({A_rows, B_cols, tile_row, tile_col, last_tile} !== {exp_t.a, exp_t.b, exp_t.r, exp_t.c, exp_t.l}) begin
                    errors++;
                    $display("[TB] FAIL b2b_tile got r%0d c%0d A=%h B=%h l=%b exp r%0d c%0d A=%h B=%h l=%b",
                             tile_row, tile_col, A_rows, B_cols, last_tile, exp_t.r, exp_t.c, exp_t.a, exp_t.b, exp_t.l);
                end
            end
            @(negedge clk);
            cyc++;
        end
        load_valid = 1'b0;
        checks++;
        if (sb_q.size() != 0 || !saw_done) begin
            errors++;
            $display("[TB] FAIL b2b_progress got left=%0d saw_done=%0d exp 0 1", sb_q.size(), saw_done);
            sb_q.delete();
        end
        check_done_pulse("b2b");
    endtask

    task automatic test_reset_mid();
        logic [63:0] a, b;
        int cyc = 0;
        int popped = 0;
        bit saw_done = 0;
        make_pattern(a, b);
        start_load(a, b);
        load_valid = 1'b0;
        while (popped < 2 && cyc < 10) begin
            if (valid_out && ready_in) begin
                exp_t = sb_q.pop_front();
                popped++;
                checks++;
                if ({A_rows, B_cols, tile_row, tile_col, last_tile} !== {exp_t.a, exp_t.b, exp_t.r, exp_t.c, exp_t.l}) begin
                    errors++;
                    $display("[TB] FAIL mid_tile got r%0d c%0d A=%h B=%h exp r%0d c%0d A=%h B=%h",
                             tile_row, tile_col, A_rows, B_cols, exp_t.r, exp_t.c, exp_t.a, exp_t.b);
                end
            end
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        checks++;
        if ({load_ready, valid_out, A_rows, B_cols, tile_row, tile_col, last_tile, done} !==
            {1'b1, 1'b0, 64'h0, 4'b0}) begin
            errors++;
            $display("[TB] FAIL mid_reset got ready=%b valid=%b A=%h B=%h row=%0d col=%0d last=%b done=%b",
                     load_ready, valid_out, A_rows, B_cols, tile_row, tile_col, last_tile, done);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || valid_out) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("[TB] FAIL mid_quiet got done/valid activity after reset exp none");
        end
        start_load(a, b);
        load_valid = 1'b0;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 20) begin
            if (valid_out && ready_in) begin
                exp_t = sb_q.pop_front();
                checks++;
                if ({A_rows, B_cols, tile_row, tile_col, last_tile} !== {exp_t.a, exp_t.b, exp_t.r, exp_t.c, exp_t.l}) begin
                    errors++;
                    $display("[TB] FAIL restart_tile got r%0d c%0d A=%h B=%h exp r%0d c%0d A=%h B=%h",
                             tile_row, tile_col, A_rows, B_cols, exp_t.r, exp_t.c, exp_t.a, exp_t.b);
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("[TB] FAIL restart_timeout got %0d tiles left exp 0", sb_q.size());
            sb_q.delete();
        end
        check_done_pulse("restart");
    endtask

    task automatic test_degenerate();
        logic [15:0] a, b;
        a = 16'($urandom);
        b = 16'($urandom);
        @(negedge clk);
        dg_A_in       = a;
        dg_B_in       = b;
        dg_load_valid = 1'b1;
        @(negedge clk);
        dg_load_valid = 1'b0;
        checks++;
        if ({dg_valid_out, dg_last_tile, dg_tile_row, dg_tile_col, dg_A_rows, dg_B_cols} !== {4'b1100, a, b}) begin
            errors++;
            $display("[TB] FAIL dg_tile got v=%b l=%b r%0d c%0d A=%h B=%h exp v=1 l=1 r0 c0 A=%h B=%h",
                     dg_valid_out, dg_last_tile, dg_tile_row, dg_tile_col, dg_A_rows, dg_B_cols, a, b);
        end
        @(negedge clk);
        checks++;
        if ({dg_done, dg_valid_out, dg_load_ready} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL dg_done got done=%b valid=%b ready=%b exp 1 0 1", dg_done, dg_valid_out, dg_load_ready);
        end
        @(negedge clk);
        checks++;
        if (dg_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dg_done_width got done=%b exp 0", dg_done);
        end
    endtask

    initial begin
        rst           = 1'b1;
        load_valid    = 1'b0;
        ready_in      = 1'b1;
        A_in          = '0;
        B_in          = '0;
        dg_load_valid = 1'b0;
        dg_ready_in   = 1'b1;
        dg_A_in       = '0;
        dg_B_in       = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_single_load();
        test_backpressure();
        test_load_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_degenerate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
